spi_flash_responder: RTL and testbench

//  Synthesizable SPI-flash slave answering PROC_SUBSYSTEM's SPI_FLASH_* master pins in simulation/FPGA loopback.

---
 rtl/spi_flash_rsp_pkg.sv | 20 ++
 rtl/spi_flash_rsp_sync.sv | 27 ++
 rtl/spi_flash_responder.sv | 183 ++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_rsp_pkg.sv
// rtl/spi_flash_rsp_pkg.sv - shared state encoding and command opcodes for the SPI flash responder
package spi_flash_rsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_RDID      = 8'h9F;
    localparam logic [7:0] CMD_RDSR      = 8'h05;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

endpackage

// File: rtl/spi_flash_rsp_sync.sv
// rtl/spi_flash_rsp_sync.sv - 2-flop synchronizer with a third flop for rise/fall detection
module spi_flash_rsp_sync #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr <= {3{INIT}};
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign dout = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash slave (READ/RDID/RDSR); SPI_FLASH_RSP_FAST_READ_EN adds 0x0B
import spi_flash_rsp_pkg::*;

module spi_flash_responder #(
    parameter int          MEM_AW     = 8,
    parameter logic [23:0] JEDEC_ID   = 24'hC22017,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              SPI_FLASH_SCLK,
    input  logic              SPI_FLASH_SS_N,
    input  logic              SPI_FLASH_SDO,
    output logic              SPI_FLASH_SDI,
    input  logic              mem_we,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic [15:0]       rd_bytes
);

`ifdef SPI_FLASH_RSP_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic sdo_s, sdo_rise, sdo_fall;
    logic unused_sync;

    spi_flash_rsp_sync #(.INIT(1'b0)) u_sync_sclk (.clk(SYSCLK), .resetn(NSYSRESET), .din(SPI_FLASH_SCLK),
                                                   .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_flash_rsp_sync #(.INIT(1'b1)) u_sync_ss   (.clk(SYSCLK), .resetn(NSYSRESET), .din(SPI_FLASH_SS_N),
                                                   .dout(ss_s), .rise(ss_rise), .fall(ss_fall));
    spi_flash_rsp_sync #(.INIT(1'b0)) u_sync_sdo  (.clk(SYSCLK), .resetn(NSYSRESET), .din(SPI_FLASH_SDO),
                                                   .dout(sdo_s), .rise(sdo_rise), .fall(sdo_fall));

    assign unused_sync = ^{sclk_s, sdo_rise, sdo_fall};

    logic [7:0]        mem [0:(1<<MEM_AW)-1];
    state_t            state, nxt;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_idx;
    logic [7:0]        rx_sr, tx_sr, rx_next;
    logic              sdi_r, active, byte_done;
    logic [MEM_AW-1:0] addr, addr_inc;
    logic [MEM_AW+7:0] addr_shift;

    // A deselect in the same cycle as an SCLK edge wins: the edge is dropped.
    always_comb begin
        active     = (state != ST_IDLE) && !ss_rise;
        rx_next    = {rx_sr[6:0], sdo_s};
        byte_done  = active && sclk_rise && (bit_cnt == 3'd7);
        addr_shift = {addr, rx_next};
        addr_inc   = addr + MEM_AW'(1);
    end

    always_ff @(posedge SYSCLK) begin
        if (mem_we && ss_s) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (ss_rise) begin
            nxt = ST_IDLE;
        end else if (ss_fall) begin
            nxt = ST_CMD;
        end else if (byte_done) begin
            case (state)
                ST_CMD: begin
                    case (rx_next)
                        CMD_READ:      nxt = ST_ADDR;
                        CMD_RDID:      nxt = ST_ID;
                        CMD_RDSR:      nxt = ST_STAT;
                        CMD_FAST_READ: nxt = FAST_EN ? ST_ADDR : ST_IGNORE;
                        default:       nxt = ST_IGNORE;
                    endcase
                end
                ST_ADDR: begin
                    if (byte_idx == 2'd2) begin
                        nxt = (FAST_EN && cmd_code == CMD_FAST_READ) ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: nxt = ST_DATA;
                default:  nxt = state;
            endcase
        end
    end

    // Next byte is loaded on the completing rising edge; its MSB reaches SDI on the following fall.
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'hFF;
            sdi_r     <= 1'b1;
            addr      <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            rd_bytes  <= 16'h0000;
        end else begin
            cmd_valid <= 1'b0;
            if (ss_fall) begin
                bit_cnt  <= 3'd0;
                byte_idx <= 2'd0;
                rx_sr    <= 8'h00;
                tx_sr    <= 8'hFF;
                sdi_r    <= 1'b1;
                addr     <= '0;
                rd_bytes <= 16'h0000;
            end else if (ss_rise) begin
                bit_cnt <= 3'd0;
                tx_sr   <= 8'hFF;
                sdi_r   <= 1'b1;
            end else if (active && sclk_rise) begin
                rx_sr   <= rx_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_idx <= (byte_idx == 2'd3) ? 2'd3 : byte_idx + 2'd1;
                    case (state)
                        ST_CMD: begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= rx_next;
                            byte_idx  <= 2'd0;
                            case (rx_next)
                                CMD_RDID: begin
                                    tx_sr    <= JEDEC_ID[23:16];
                                    byte_idx <= 2'd1;
                                end
                                CMD_RDSR: tx_sr <= STATUS_VAL;
                                default:  tx_sr <= 8'hFF;
                            endcase
                        end
                        ST_ADDR: begin
                            addr  <= addr_shift[MEM_AW-1:0];
                            tx_sr <= mem[addr_shift[MEM_AW-1:0]];
                        end
                        ST_DUMMY: tx_sr <= mem[addr];
                        ST_DATA: begin
                            addr     <= addr_inc;
                            tx_sr    <= mem[addr_inc];
                            rd_bytes <= (rd_bytes == 16'hFFFF) ? rd_bytes : rd_bytes + 16'd1;
                        end
                        ST_ID: begin
                            case (byte_idx)
                                2'd1:    tx_sr <= JEDEC_ID[15:8];
                                2'd2:    tx_sr <= JEDEC_ID[7:0];
                                default: tx_sr <= 8'hFF;
                            endcase
                        end
                        ST_STAT: tx_sr <= STATUS_VAL;
                        default: tx_sr <= 8'hFF;
                    endcase
                end
            end else if (active && sclk_fall) begin
                sdi_r <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b1};
            end
        end
    end

    always_comb begin
        SPI_FLASH_SDI = 1'b1;
        if (state == ST_DATA || state == ST_ID || state == ST_STAT) begin
            SPI_FLASH_SDI = sdi_r;
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed table-driven bench for spi_flash_responder
module tb_spi_flash_responder;

    logic        SYSCLK = 1'b0;
    logic        NSYSRESET;
    logic        SPI_FLASH_SCLK;
    logic        SPI_FLASH_SS_N;
    logic        SPI_FLASH_SDO;
    logic        SPI_FLASH_SDI;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] rd_bytes;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) if (cmd_valid === 1'b1) pulses++;

    spi_flash_responder dut (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
        .SPI_FLASH_SCLK(SPI_FLASH_SCLK), .SPI_FLASH_SS_N(SPI_FLASH_SS_N),
        .SPI_FLASH_SDO(SPI_FLASH_SDO), .SPI_FLASH_SDI(SPI_FLASH_SDI),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .rd_bytes(rd_bytes)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic        has_addr;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge SYSCLK);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < n; b++) begin
            SPI_FLASH_SDO = tx[7-b];
            half();
            rx = {rx[6:0], SPI_FLASH_SDI};
            SPI_FLASH_SCLK = 1'b1;
            half();
            SPI_FLASH_SCLK = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic select();
        SPI_FLASH_SS_N = 1'b0;
        half();
    endtask

    task automatic deselect();
        half();
        SPI_FLASH_SS_N = 1'b1;
        half();
    endtask

    task automatic send_read_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] rx;
        spi_byte(cmd, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge SYSCLK);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        @(negedge SYSCLK);
        mem_we = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] rx;
        int p0;
        p0 = pulses;
        select();
        if (v.has_addr) send_read_hdr(v.cmd, v.addr);
        else spi_byte(v.cmd, rx);
        for (int i = 0; i < v.nbytes; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("vec%0d byte%0d", idx, i), {24'h0, rx}, {24'h0, v.exp[31-8*i -: 8]});
        end
        deselect();
        check($sformatf("vec%0d rd_bytes", idx), {16'h0, rd_bytes}, {16'h0, v.exp_rd});
        check($sformatf("vec%0d cmd_code", idx), {24'h0, cmd_code}, {24'h0, v.cmd});
        check($sformatf("vec%0d cmd_valid pulses", idx), pulses - p0, 32'd1);
    endtask

    initial begin
        logic [7:0] rx;

        vecs[0] = '{8'h03, 1'b1, 24'h000010, 4, 32'h11223344, 16'd4};
        vecs[1] = '{8'h9F, 1'b0, 24'h000000, 4, 32'hC22017FF, 16'd0};
        vecs[2] = '{8'h05, 1'b0, 24'h000000, 3, 32'h00000000, 16'd0};
        vecs[3] = '{8'h03, 1'b1, 24'h0000FF, 2, 32'hAA550000, 16'd2};
        vecs[4] = '{8'h03, 1'b1, 24'hABCD12, 2, 32'h33440000, 16'd2};
        vecs[5] = '{8'h42, 1'b0, 24'h000000, 2, 32'hFFFF0000, 16'd0};

        NSYSRESET = 1'b0;
        SPI_FLASH_SCLK = 1'b0; SPI_FLASH_SS_N = 1'b1; SPI_FLASH_SDO = 1'b0;
        mem_we = 1'b0; mem_addr = 8'h00; mem_wdata = 8'h00;
        repeat (4) @(negedge SYSCLK);
        NSYSRESET = 1'b1;
        @(negedge SYSCLK);

        check("reset sdi",       {31'h0, SPI_FLASH_SDI}, 32'd1);
        check("reset cmd_valid", {31'h0, cmd_valid},     32'd0);
        check("reset cmd_code",  {24'h0, cmd_code},      32'd0);
        check("reset rd_bytes",  {16'h0, rd_bytes},      32'd0);

        host_write(8'h10, 8'h11);
        host_write(8'h11, 8'h22);
        host_write(8'h12, 8'h33);
        host_write(8'h13, 8'h44);
        host_write(8'hFF, 8'hAA);
        host_write(8'h00, 8'h55);
        host_write(8'h20, 8'h5A);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Abort mid-byte, then a fresh READ must start cleanly
        select();
        send_read_hdr(8'h03, 24'h000010);
        spi_bits(8'h00, 4, rx);
        SPI_FLASH_SS_N = 1'b1;
        repeat (6) @(negedge SYSCLK);
        check("abort sdi idle", {31'h0, SPI_FLASH_SDI}, 32'd1);
        check("abort rd_bytes", {16'h0, rd_bytes}, 32'd0);
        half();
        select();
        send_read_hdr(8'h03, 24'h000010);
        spi_byte(8'h00, rx);
        check("after abort byte0", {24'h0, rx}, 32'h11);
        deselect();

        // Host writes are dropped while selected, accepted while deselected
        select();
        spi_byte(8'h05, rx);
        host_write(8'h20, 8'h99);
        spi_byte(8'h00, rx);
        deselect();
        host_write(8'h21, 8'h77);
        select();
        send_read_hdr(8'h03, 24'h000020);
        spi_byte(8'h00, rx);
        check("dropped write", {24'h0, rx}, 32'h5A);
        spi_byte(8'h00, rx);
        check("accepted write", {24'h0, rx}, 32'h77);
        deselect();

        select();
`ifdef SPI_FLASH_RSP_FAST_READ_EN
        send_read_hdr(8'h0B, 24'h000010);
        spi_byte(8'h00, rx);
        check("fast dummy", {24'h0, rx}, 32'hFF);
        spi_byte(8'h00, rx);
        check("fast byte0", {24'h0, rx}, 32'h11);
        spi_byte(8'h00, rx);
        check("fast byte1", {24'h0, rx}, 32'h22);
        deselect();
        check("fast rd_bytes", {16'h0, rd_bytes}, 32'd2);
`else
        spi_byte(8'h0B, rx);
        for (int i = 0; i < 5; i++) begin
            spi_byte(8'h00, rx);
            check($sformatf("0x0B ignored byte%0d", i), {24'h0, rx}, 32'hFF);
        end
        deselect();
        check("0x0B rd_bytes", {16'h0, rd_bytes}, 32'd0);
`endif
        check("0x0B cmd_code", {24'h0, cmd_code}, 32'h0B);

        // Reset in the middle of a DATA byte
        select();
        send_read_hdr(8'h03, 24'h000010);
        spi_byte(8'h00, rx);
        check("pre-reset byte0", {24'h0, rx}, 32'h11);
        check("pre-reset rd_bytes", {16'h0, rd_bytes}, 32'd1);
        spi_bits(8'h00, 3, rx);
        @(negedge SYSCLK);
        NSYSRESET = 1'b0;
        @(negedge SYSCLK);
        check("mid-reset sdi",      {31'h0, SPI_FLASH_SDI}, 32'd1);
        check("mid-reset rd_bytes", {16'h0, rd_bytes},      32'd0);
        check("mid-reset cmd_code", {24'h0, cmd_code},      32'd0);
        NSYSRESET = 1'b1;
        deselect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
